mbist_op_seq: RTL

//  Parametrised march-element sequencer for the MBIST controller: a scan-loaded table of up to ELEM_MAX elements, OPS_MAX ops each.

---
 rtl/mbist_op_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mbist_op_seq.sv
// mbist_op_seq: march-element sequencer stepping ops from a scan-loaded element table.
// Define MBIST_RETENTION_EN to compile the per-element retention pause (PAUSE state + counter).
module mbist_op_seq #(
    parameter int unsigned OPS_MAX  = 8,
    parameter int unsigned ELEM_MAX = 8,
    parameter int unsigned OPC_WD   = (OPS_MAX  > 1) ? $clog2(OPS_MAX)  : 1,
    parameter int unsigned ECNT_WD  = (ELEM_MAX > 1) ? $clog2(ELEM_MAX) : 1
`ifdef MBIST_RETENTION_EN
   ,parameter int unsigned RET_WD   = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_shift,
    input  logic               sdi,
    output logic               sdo,
    input  logic               start,
    input  logic               step,
    input  logic               addr_last,
    input  logic               re_init,
    output logic               op_valid,
    output logic               op_read,
    output logic               op_write,
    output logic               op_invert,
    output logic               op_updown,
    output logic               op_reverse,
    output logic               op_repeatflag,
    output logic               last_op,
    output logic [ECNT_WD-1:0] elem_idx,
    output logic               elem_done,
    output logic               done
);

`ifdef MBIST_RETENTION_EN
    localparam int unsigned PAUSE_WD = 1;
`else
    localparam int unsigned PAUSE_WD = 0;
`endif
    localparam int unsigned OP_BITS = 3 * OPS_MAX;
    localparam int unsigned EL_WD   = OP_BITS + OPC_WD + 3 + PAUSE_WD;
    localparam int unsigned CH_WD   = ECNT_WD + ELEM_MAX * EL_WD;
    localparam int unsigned RPT_POS = OP_BITS + OPC_WD;
    localparam logic [OPC_WD-1:0]  OPC_SAT   = OPC_WD'(OPS_MAX - 1);
    localparam logic [ECNT_WD-1:0] ELAST_SAT = ECNT_WD'(ELEM_MAX - 1);

`ifdef MBIST_RETENTION_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_PAUSE} state_e;
    localparam logic [RET_WD-1:0] RET_ALL  = '1;
    localparam logic [RET_WD-1:0] RET_INIT = RET_ALL - 1'b1;
    logic [RET_WD-1:0] cnt_q;
    logic              pause_fin;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
`endif

    state_e             state_q;
    logic [CH_WD-1:0]   chain_q;
    logic [OPC_WD-1:0]  op_ptr_q;
    logic [ECNT_WD-1:0] elem_idx_q;

    logic [EL_WD-1:0]   elems   [ELEM_MAX];
    logic [2:0]         cur_ops [OPS_MAX];
    logic [EL_WD-1:0]   cur_el;
    logic [OPC_WD-1:0]  opc_eff;
    logic [ECNT_WD-1:0] elem_last_eff;
    logic [ECNT_WD-1:0] idx_inc;
    logic [2:0]         cur_op;
    logic               run, at_last, last_elem, op_fin;
    state_e             start_state, adv_state;

    for (genvar e = 0; e < ELEM_MAX; e++) begin : g_el
        assign elems[e] = chain_q[ECNT_WD + e*EL_WD +: EL_WD];
    end

    for (genvar i = 0; i < OPS_MAX; i++) begin : g_op
        assign cur_ops[i] = cur_el[3*i +: 3];
    end

    always_comb begin
        cur_el        = elems[elem_idx_q];
        opc_eff       = (cur_el[OP_BITS +: OPC_WD] > OPC_SAT) ? OPC_SAT : cur_el[OP_BITS +: OPC_WD];
        elem_last_eff = (chain_q[ECNT_WD-1:0] > ELAST_SAT) ? ELAST_SAT : chain_q[ECNT_WD-1:0];
        idx_inc       = elem_idx_q + 1'b1;
        cur_op        = cur_ops[op_ptr_q];
        run           = (state_q == S_RUN);
        at_last       = (op_ptr_q == opc_eff);
        last_elem     = (elem_idx_q == elem_last_eff);
        // re_init and scan_shift both suppress the element-finish event
        op_fin        = run && !scan_shift && !re_init && step && at_last && addr_last;
`ifdef MBIST_RETENTION_EN
        pause_fin     = (state_q == S_PAUSE) && !scan_shift && (cnt_q == '0);
        start_state   = elems[0][EL_WD-1] ? S_PAUSE : S_RUN;
        adv_state     = last_elem ? S_DONE : (elems[idx_inc][EL_WD-1] ? S_PAUSE : S_RUN);
`else
        start_state   = S_RUN;
        adv_state     = last_elem ? S_DONE : S_RUN;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            chain_q    <= '0;
            op_ptr_q   <= '0;
            elem_idx_q <= '0;
`ifdef MBIST_RETENTION_EN
            cnt_q      <= '0;
`endif
        end else if (scan_shift) begin
            state_q    <= S_IDLE;
            chain_q    <= {sdi, chain_q[CH_WD-1:1]};
            op_ptr_q   <= '0;
            elem_idx_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= start_state;
                        op_ptr_q   <= '0;
                        elem_idx_q <= '0;
`ifdef MBIST_RETENTION_EN
                        cnt_q      <= RET_INIT;
`endif
                    end
                end
                S_RUN: begin
                    if (re_init) begin
                        op_ptr_q <= '0;
                    end else if (step) begin
                        if (at_last) begin
                            op_ptr_q <= '0;
                            if (addr_last) begin
                                state_q <= adv_state;
                                if (!last_elem) elem_idx_q <= idx_inc;
`ifdef MBIST_RETENTION_EN
                                cnt_q   <= RET_INIT;
`endif
                            end
                        end else begin
                            op_ptr_q <= op_ptr_q + 1'b1;
                        end
                    end
                end
`ifdef MBIST_RETENTION_EN
                S_PAUSE: begin
                    if (cnt_q == '0) begin
                        state_q <= adv_state;
                        if (!last_elem) elem_idx_q <= idx_inc;
                        cnt_q   <= RET_INIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sdo           = chain_q[0];
    assign op_valid      = run;
    assign op_invert     = run & cur_op[0];
    assign op_read       = run & cur_op[1];
    assign op_write      = run & cur_op[2];
    assign op_repeatflag = run & cur_el[RPT_POS];
    assign op_reverse    = run & cur_el[RPT_POS + 1];
    assign op_updown     = run & cur_el[RPT_POS + 2];
    assign last_op       = run & at_last & ~re_init;
    assign elem_idx      = elem_idx_q;
    assign done          = (state_q == S_DONE);
`ifdef MBIST_RETENTION_EN
    assign elem_done     = op_fin | pause_fin;
`else
    assign elem_done     = op_fin;
`endif

endmodule
